// File: rtl/ui_device_responder_pkg.sv
// Shared UI device codes and active-low 7-segment glyphs for the UI device responder.
`default_nettype none

package ui_device_responder_pkg;

  typedef enum logic [1:0] {
    UI_HEX  = 2'd0,
    UI_LEDR = 2'd1,
    UI_KEY  = 2'd2,
    UI_SW   = 2'd3
  } ui_device_e;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

`default_nettype wire

// File: rtl/hex_digit_decoder.sv
// Nibble to active-low 7-segment glyph (0-9, A-F) for one HEX digit.
`default_nettype none

module hex_digit_decoder
  import ui_device_responder_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = GLYPH_0;
    case (nibble)
      4'h0: segments = GLYPH_0;
      4'h1: segments = GLYPH_1;
      4'h2: segments = GLYPH_2;
      4'h3: segments = GLYPH_3;
      4'h4: segments = GLYPH_4;
      4'h5: segments = GLYPH_5;
      4'h6: segments = GLYPH_6;
      4'h7: segments = GLYPH_7;
      4'h8: segments = GLYPH_8;
      4'h9: segments = GLYPH_9;
      4'hA: segments = GLYPH_A;
      4'hB: segments = GLYPH_B;
      4'hC: segments = GLYPH_C;
      4'hD: segments = GLYPH_D;
      4'hE: segments = GLYPH_E;
      default: segments = GLYPH_F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ui_device_responder.sv
// Device-side UI bus responder: HEX/LEDR registers, KEY sync+debounce, SW sync.
// Optional KEY_EDGE_CAPTURE_EN adds per-key sticky press bits, cleared by a UI_KEY read.
`default_nettype none

module ui_device_responder
  import ui_device_responder_pkg::*;
#(
  parameter int DBITS           = 32,
  parameter int HEX_DIGITS      = 6,
  parameter int LEDR_BITS       = 10,
  parameter int KEY_BITS        = 4,
  parameter int SW_BITS         = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DBITS-1:0]        wrData,
  input  logic                    wrEn,
  input  logic                    rdEn,
  input  logic [1:0]              device,
  output logic [DBITS-1:0]        rdData,
  input  logic [KEY_BITS-1:0]     KEY,
  input  logic [SW_BITS-1:0]      SW,
  output logic [LEDR_BITS-1:0]    LEDR,
  output logic [7*HEX_DIGITS-1:0] HEX
);

  localparam int HEX_BITS = 4 * HEX_DIGITS;
  localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [HEX_BITS-1:0]  hex_reg;
  logic [LEDR_BITS-1:0] ledr_reg;
  logic [KEY_BITS-1:0]  key_meta_n;
  logic [KEY_BITS-1:0]  key_sync_n;
  logic [KEY_BITS-1:0]  key_sync;
  logic [KEY_BITS-1:0]  key_stable;
  logic [KEY_BITS-1:0]  key_rise;
  logic [SW_BITS-1:0]   sw_meta;
  logic [SW_BITS-1:0]   sw_sync;
  logic                 unused_bits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_reg  <= '0;
      ledr_reg <= '0;
    end else if (wrEn) begin
      if (device == UI_HEX)  hex_reg  <= wrData[HEX_BITS-1:0];
      if (device == UI_LEDR) ledr_reg <= wrData[LEDR_BITS-1:0];
    end
  end

  assign LEDR = ledr_reg;

  // Key flops carry raw pin polarity so reset lands them in the released state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta_n <= '1;
      key_sync_n <= '1;
      sw_meta    <= '0;
      sw_sync    <= '0;
    end else begin
      key_meta_n <= KEY;
      key_sync_n <= key_meta_n;
      sw_meta    <= SW;
      sw_sync    <= sw_meta;
    end
  end

  assign key_sync = ~key_sync_n;

  for (genvar k = 0; k < KEY_BITS; k++) begin : g_debounce
    logic [CNT_W-1:0] cnt;
    logic             stable;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt    <= '0;
        stable <= 1'b0;
      end else if (key_sync[k] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= key_sync[k];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign key_stable[k] = stable;
    assign key_rise[k]   = ~stable & key_sync[k] & (cnt == CNT_LAST);
  end

`ifdef KEY_EDGE_CAPTURE_EN
  logic [KEY_BITS-1:0] sticky;
  logic                sticky_clr;

  assign sticky_clr = rdEn && (device == UI_KEY);

  // A rise on the clearing edge wins so no press is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sticky <= '0;
    else          sticky <= (sticky_clr ? '0 : sticky) | key_rise;
  end

  assign unused_bits = ^wrData;
`else
  assign unused_bits = ^{rdEn, wrData, key_rise};
`endif

  always_comb begin
    rdData = '0;
    case (device)
      UI_HEX:  rdData[HEX_BITS-1:0]  = hex_reg;
      UI_LEDR: rdData[LEDR_BITS-1:0] = ledr_reg;
      UI_SW:   rdData[SW_BITS-1:0]   = sw_sync;
      UI_KEY: begin
        rdData[KEY_BITS-1:0] = key_stable;
`ifdef KEY_EDGE_CAPTURE_EN
        rdData[2*KEY_BITS-1:KEY_BITS] = sticky;
`endif
      end
      default: rdData = '0;
    endcase
  end

  for (genvar i = 0; i < HEX_DIGITS; i++) begin : g_hex
    hex_digit_decoder u_dec (
      .nibble   (hex_reg[4*i +: 4]),
      .segments (HEX[7*i +: 7])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_ui_device_responder.sv
// Directed self-checking bench for ui_device_responder (DEBOUNCE_CYCLES=4).
`default_nettype none

module tb_ui_device_responder;
  import ui_device_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] wrData;
  logic        wrEn;
  logic        rdEn;
  logic [1:0]  device;
  logic [31:0] rdData;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [41:0] HEX;

  int total = 0;
  int bad   = 0;

  localparam logic [41:0] HEX_ZEROS = {6{7'b1000000}};

  ui_device_responder #(
    .DBITS(32), .HEX_DIGITS(6), .LEDR_BITS(10), .KEY_BITS(4), .SW_BITS(10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wrData(wrData), .wrEn(wrEn), .rdEn(rdEn),
    .device(device), .rdData(rdData), .KEY(KEY), .SW(SW), .LEDR(LEDR), .HEX(HEX)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] dev);
    device = dev;
    #1;
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [41:0] hex_exp(input logic [23:0] v);
    logic [41:0] r;
    for (int i = 0; i < 6; i++) r[7*i +: 7] = glyph(v[4*i +: 4]);
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; wrData = '0; wrEn = 1'b0; rdEn = 1'b0;
    device = UI_HEX; KEY = 4'hF; SW = '0;
    tick(3);
    reset_n = 1'b1;
    tick();

    // reset state
    check("rst_ledr", 64'(LEDR), 64'h0);
    check("rst_hex", 64'(HEX), 64'(HEX_ZEROS));
    rd(UI_HEX); check("rst_rd_hex", 64'(rdData), 64'h0);
    rd(UI_KEY); check("rst_rd_key", 64'(rdData), 64'h0);
    rd(UI_SW);  check("rst_rd_sw", 64'(rdData), 64'h0);

    // HEX write and decode
    wrEn = 1'b1; device = UI_HEX; wrData = 32'h00ABC123;
    tick();
    wrEn = 1'b0;
    check("hex_all", 64'(HEX), 64'(hex_exp(24'hABC123)));
    check("hex_d0", 64'(HEX[6:0]), 64'(7'b0110000));
    check("hex_d5", 64'(HEX[41:35]), 64'(7'b0001000));
    rd(UI_HEX); check("rd_hex", 64'(rdData), 64'h00ABC123);

    wrEn = 1'b1; device = UI_HEX; wrData = 32'h00F0E8D9;
    tick();
    wrEn = 1'b0;
    check("hex_all2", 64'(HEX), 64'(hex_exp(24'hF0E8D9)));

    // LEDR write, then writes to input devices and idle cycles change nothing
    wrEn = 1'b1; device = UI_LEDR; wrData = 32'hFFFFFFFF;
    tick();
    wrEn = 1'b0;
    check("ledr", 64'(LEDR), 64'h3FF);
    rd(UI_LEDR); check("rd_ledr", 64'(rdData), 64'h3FF);
    wrEn = 1'b1; device = UI_SW; wrData = 32'h0;
    tick();
    device = UI_KEY;
    tick();
    wrEn = 1'b0; device = 2'bxx; wrData = 32'h12345678;
    tick();
    check("ledr_hold", 64'(LEDR), 64'h3FF);
    check("hex_hold", 64'(HEX), 64'(hex_exp(24'hF0E8D9)));
    rd(UI_SW); check("sw_no_write", 64'(rdData), 64'h0);

    // SW synchronizer: two-cycle latency
    SW = 10'h2A5;
    tick();
    rd(UI_SW); check("sw_1cyc", 64'(rdData), 64'h0);
    tick();
    check("sw_2cyc", 64'(rdData), 64'h2A5);

    // KEY[0] press: accepted exactly 6 cycles later
    device = UI_KEY;
    KEY[0] = 1'b0;
    tick(5);
    check("key0_5cyc", 64'(rdData[0]), 64'h0);
    tick();
    check("key0_6cyc", 64'(rdData[0]), 64'h1);
    KEY[0] = 1'b1;
    tick(5);
    check("key0_rel_5cyc", 64'(rdData[0]), 64'h1);
    tick();
    check("key0_rel_6cyc", 64'(rdData[0]), 64'h0);

    // bouncing pin never accepted
    for (int i = 0; i < 8; i++) begin
      KEY[0] = 1'b0;
      tick();
      KEY[0] = 1'b1;
      tick(2);
      check("key0_glitch", 64'(rdData[0]), 64'h0);
    end
    tick(6);

`ifdef KEY_EDGE_CAPTURE_EN
    // sticky from the KEY[0] press above is bit 4
    KEY[2] = 1'b0;
    tick(6);
    KEY[2] = 1'b1;
    tick(6);
    rd(UI_KEY); check("sticky_set", 64'(rdData), 64'h50);
    rdEn = 1'b1;
    #1; check("sticky_old_on_clear", 64'(rdData), 64'h50);
    tick();
    rdEn = 1'b0;
    check("sticky_cleared", 64'(rdData), 64'h0);
    KEY[2] = 1'b0;
    tick(5);
    check("sticky_pre_rise", 64'(rdData), 64'h0);
    rdEn = 1'b1;
    tick();
    rdEn = 1'b0;
    check("sticky_rise_vs_clear", 64'(rdData), 64'h44);
    KEY[2] = 1'b1;
    tick(6);
    check("sticky_kept", 64'(rdData), 64'h40);
`else
    KEY[2] = 1'b0;
    tick(6);
    rd(UI_KEY); rdEn = 1'b1;
    #1; check("key2_noedge", 64'(rdData), 64'h4);
    tick();
    rdEn = 1'b0;
    check("key2_rden_noeffect", 64'(rdData), 64'h4);
    KEY[2] = 1'b1;
    tick(6);
    check("key2_released", 64'(rdData), 64'h0);
`endif

    // async reset mid-run with KEY[1] held pressed
    KEY[1] = 1'b0;
    tick(6);
    rd(UI_KEY); check("key1_pressed", 64'(rdData[1]), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ledr", 64'(LEDR), 64'h0);
    check("arst_hex", 64'(HEX), 64'(HEX_ZEROS));
    rd(UI_KEY); check("arst_rd_key", 64'(rdData), 64'h0);
    rd(UI_SW);  check("arst_rd_sw", 64'(rdData), 64'h0);
    #2;
    reset_n = 1'b1;
    tick(2);
    rd(UI_KEY); check("post_rst_key", 64'(rdData), 64'h0);
    KEY[1] = 1'b1;
    tick(6);
    check("post_rst_key_idle", 64'(rdData), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
